smaqa_wb_unit: RTL and testbench

//  Write-back end of the multiplier result interface. Records the destination register (rd) per trans_id at issue.

---
 rtl/smaqa_wb_pkg.sv | 21 ++
 rtl/smaqa_wb_unit_if.sv | 41 ++++
 rtl/smaqa_wb_fifo.sv | 65 ++++++
 rtl/smaqa_wb_unit.sv | 120 ++++++++++++
 tb/tb_smaqa_wb_unit.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/smaqa_wb_pkg.sv
// Shared types and widths for the multiplier write-back unit.
// TIDW/XLEN mirror ariane_pkg::TRANS_ID_BITS and riscv::XLEN of the host core.
package smaqa_wb_pkg;

    localparam int unsigned TIDW          = 3;
    localparam int unsigned XLEN          = 64;
    localparam int unsigned DEPTH_DEFAULT = 4;
    localparam int unsigned NTAGS         = 1 << TIDW;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        logic [TIDW-1:0] tid;
    } wb_entry_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } tag_t;

endpackage

// File: rtl/smaqa_wb_unit_if.sv
// Issue, multiplier-result and regfile/scoreboard write-back signals of smaqa_wb_unit.
// The slave modport is the unit's view; master is the surrounding pipeline.
interface smaqa_wb_unit_if;
    import smaqa_wb_pkg::*;

    logic            issue_valid_i;
    logic [TIDW-1:0] issue_trans_id_i;
    logic [4:0]      issue_rd_i;
    logic            issue_ready_o;

    logic            mult_valid_i;
    logic [TIDW-1:0] mult_trans_id_i;
    logic [XLEN-1:0] mult_result_i;

    logic [4:0]      waddr_o;
    logic [XLEN-1:0] wdata_o;
    logic            we_o;
    logic            wb_valid_o;
    logic [TIDW-1:0] wb_trans_id_o;
    logic            wb_gnt_i;
    logic            err_o;

    modport slave (
        input  issue_valid_i, issue_trans_id_i, issue_rd_i,
        output issue_ready_o,
        input  mult_valid_i, mult_trans_id_i, mult_result_i,
        output waddr_o, wdata_o, we_o, wb_valid_o, wb_trans_id_o,
        input  wb_gnt_i,
        output err_o
    );

    modport master (
        output issue_valid_i, issue_trans_id_i, issue_rd_i,
        input  issue_ready_o,
        output mult_valid_i, mult_trans_id_i, mult_result_i,
        input  waddr_o, wdata_o, we_o, wb_valid_o, wb_trans_id_o,
        output wb_gnt_i,
        input  err_o
    );

endinterface

// File: rtl/smaqa_wb_fifo.sv
// Result FIFO of wb_entry_t; head is read combinationally from registered storage.
// A push while full is accepted only when a pop frees the head slot in the same cycle.
module smaqa_wb_fifo
    import smaqa_wb_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  wb_entry_t                entry_i,
    input  logic                     pop_i,
    output wb_entry_t                head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    wb_entry_t   mem_q [DEPTH];
    logic        push_ok;
    logic        pop_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; outputs are qualified by the non-empty flag.
    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= entry_i;
        end
    end

    overflow_drop: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && full_o && !pop_ok));

endmodule

// File: rtl/smaqa_wb_unit.sv
// Write-back end of the multiplier: records rd per trans_id at issue, pairs results with
// their rd, buffers them and drains one entry per cycle to the regfile and scoreboard.
module smaqa_wb_unit
    import smaqa_wb_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    smaqa_wb_unit_if.slave   bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [NTAGS-1:0] tag_valid;
    logic [4:0]       tag_rd [NTAGS];

    logic [CW-1:0]    credits_q, credits_d;
    logic             err_q, err_d;

    logic             issue_ready;
    logic             issue_fire;
    logic             mult_hit;
    logic             fifo_push;
    logic             fifo_pop;
    wb_entry_t        fifo_in;
    wb_entry_t        fifo_head;
    logic [$clog2(DEPTH):0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             wb_valid;

    assign issue_ready = !tag_valid[bus.issue_trans_id_i] && (credits_q < DEPTH_C);
    assign issue_fire  = bus.issue_valid_i && issue_ready && !flush_i;
    assign mult_hit    = bus.mult_valid_i && tag_valid[bus.mult_trans_id_i];

    // Tag table: an issued op and its result can never target the same entry in one cycle.
    for (genvar gi = 0; gi < NTAGS; gi++) begin : g_tag
        tag_t tag_q, tag_d;

        always_comb begin
            tag_d = tag_q;
            if (flush_i) begin
                tag_d = '0;
            end else if (issue_fire && (bus.issue_trans_id_i == TIDW'(gi))) begin
                tag_d.valid = 1'b1;
                tag_d.rd    = bus.issue_rd_i;
            end else if (mult_hit && (bus.mult_trans_id_i == TIDW'(gi))) begin
                tag_d.valid = 1'b0;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                tag_q <= '0;
            end else begin
                tag_q <= tag_d;
            end
        end

        assign tag_valid[gi] = tag_q.valid;
        assign tag_rd[gi]    = tag_q.rd;
    end

    assign fifo_in.rd   = tag_rd[bus.mult_trans_id_i];
    assign fifo_in.data = bus.mult_result_i;
    assign fifo_in.tid  = bus.mult_trans_id_i;
    assign fifo_push    = mult_hit && !flush_i;

    assign wb_valid = !fifo_empty && !flush_i;
    assign fifo_pop = wb_valid && bus.wb_gnt_i;

    smaqa_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (fifo_push),
        .entry_i (fifo_in),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A capture moves a credit from the tag table to the FIFO, so only issue and pop count.
    always_comb begin
        credits_d = credits_q + {{(CW-1){1'b0}}, issue_fire} - {{(CW-1){1'b0}}, fifo_pop};
        if (flush_i) begin
            credits_d = '0;
        end
        err_d = err_q | (bus.mult_valid_i && !tag_valid[bus.mult_trans_id_i]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            credits_q <= '0;
            err_q     <= 1'b0;
        end else begin
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

    assign bus.issue_ready_o = issue_ready;
    assign bus.wb_valid_o    = wb_valid;
    assign bus.we_o          = wb_valid && (fifo_head.rd != 5'd0);
    assign bus.waddr_o       = wb_valid ? fifo_head.rd   : '0;
    assign bus.wdata_o       = wb_valid ? fifo_head.data : '0;
    assign bus.wb_trans_id_o = wb_valid ? fifo_head.tid  : '0;
    assign bus.err_o         = err_q;

    credits_cover_fifo: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (CW'(fifo_count) <= credits_q) && !(fifo_full && fifo_empty));

endmodule

// File: tb/tb_smaqa_wb_unit.sv
// Directed plus randomized bench for smaqa_wb_unit, checked every cycle against a
// queue-based model of the tag table, result buffer and sticky error flag.
module tb_smaqa_wb_unit;
    import smaqa_wb_pkg::*;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    logic flush_i = 1'b0;

    smaqa_wb_unit_if bus ();

    smaqa_wb_unit #(.DEPTH(4)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Model state: pending tags, queued results awaiting retirement, sticky error.
    bit         m_tv  [8];
    logic [4:0] m_rd  [8];
    wb_entry_t  m_q   [$];
    bit         m_err;

    // Current stimulus, held for the model update at the clock edge.
    bit          c_iv, c_mv, c_gnt, c_fl;
    int          c_itid, c_ird, c_mtid;
    logic [63:0] c_res;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int credits();
        int n = m_q.size();
        for (int i = 0; i < 8; i++) n += int'(m_tv[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_tv[i] = 1'b0;
            m_rd[i] = '0;
        end
        m_q.delete();
        m_err = 1'b0;
    endtask

    task automatic drive(bit iv, int itid, int ird, bit mv, int mtid, logic [63:0] res, bit gnt, bit fl);
        c_iv = iv; c_itid = itid; c_ird = ird;
        c_mv = mv; c_mtid = mtid; c_res = res;
        c_gnt = gnt; c_fl = fl;
        bus.issue_valid_i    = iv;
        bus.issue_trans_id_i = itid[2:0];
        bus.issue_rd_i       = ird[4:0];
        bus.mult_valid_i     = mv;
        bus.mult_trans_id_i  = mtid[2:0];
        bus.mult_result_i    = res;
        bus.wb_gnt_i         = gnt;
        flush_i              = fl;
    endtask

    // Called at posedge+1 with inputs driven: check outputs mid-cycle, then advance the model.
    task automatic cycle();
        bit        exp_rdy, exp_v, exp_we, pop, hit;
        wb_entry_t hd;
        wb_entry_t e;
        #4;
        exp_rdy = !m_tv[c_itid] && (credits() < 4);
        exp_v   = (m_q.size() > 0) && !c_fl;
        hd      = exp_v ? m_q[0] : '0;
        exp_we  = exp_v && (hd.rd != 0);
        chk("issue_ready", 64'(bus.issue_ready_o), 64'(exp_rdy));
        chk("wb_valid",    64'(bus.wb_valid_o),    64'(exp_v));
        chk("we",          64'(bus.we_o),          64'(exp_we));
        chk("waddr",       64'(bus.waddr_o),       64'(hd.rd));
        chk("wdata",       bus.wdata_o,            hd.data);
        chk("wb_tid",      64'(bus.wb_trans_id_o), 64'(hd.tid));
        chk("err",         64'(bus.err_o),         64'(m_err));
        @(posedge clk_i);
        pop = exp_v && c_gnt;
        hit = c_mv && m_tv[c_mtid];
        if (c_mv && !m_tv[c_mtid]) m_err = 1'b1;
        if (c_fl) begin
            for (int i = 0; i < 8; i++) m_tv[i] = 1'b0;
            m_q.delete();
        end else begin
            if (pop) void'(m_q.pop_front());
            if (hit) begin
                e.rd   = m_rd[c_mtid];
                e.data = c_res;
                e.tid  = c_mtid[2:0];
                m_q.push_back(e);
                m_tv[c_mtid] = 1'b0;
            end
            if (c_iv && exp_rdy) begin
                m_tv[c_itid] = 1'b1;
                m_rd[c_itid] = c_ird[4:0];
            end
        end
        #1;
    endtask

    task automatic idle(bit gnt);
        drive(1'b0, 0, 0, 1'b0, 0, 64'h0, gnt, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int pend [$];
        model_reset();
        idle(1'b0);
        rst_ni = 1'b0;
        #2;
        chk("rst_we",       64'(bus.we_o),          64'd0);
        chk("rst_wb_valid", 64'(bus.wb_valid_o),    64'd0);
        chk("rst_ready",    64'(bus.issue_ready_o), 64'd1);
        chk("rst_err",      64'(bus.err_o),         64'd0);
        chk("rst_waddr",    64'(bus.waddr_o),       64'd0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Basic SMAQA result: tid 2 -> rd 3, value 0x4F.
        drive(1'b1, 2, 3, 1'b0, 0, 64'h0, 1'b1, 1'b0);  cycle();
        drive(1'b0, 0, 0, 1'b1, 2, 64'h4F, 1'b1, 1'b0); cycle();
        drive(1'b0, 2, 0, 1'b0, 0, 64'h0, 1'b1, 1'b0);
        #1;
        chk("basic_waddr", 64'(bus.waddr_o),       64'd3);
        chk("basic_wdata", bus.wdata_o,            64'h4F);
        chk("basic_we",    64'(bus.we_o),          64'd1);
        chk("basic_tid",   64'(bus.wb_trans_id_o), 64'd2);
        chk("basic_tag2_free", 64'(bus.issue_ready_o), 64'd1);
        cycle();

        // Backpressure: fill all four credits with the write port stalled.
        for (int t = 0; t < 4; t++) begin
            drive(1'b1, t, 10 + t, 1'b0, 0, 64'h0, 1'b0, 1'b0);    cycle();
            drive(1'b0, 0, 0, 1'b1, t, 64'h100 + 64'(t), 1'b0, 1'b0); cycle();
        end
        drive(1'b1, 4, 1, 1'b0, 0, 64'h0, 1'b0, 1'b0);
        #1;
        chk("bp_ready_full", 64'(bus.issue_ready_o), 64'd0);
        chk("bp_head_tid",   64'(bus.wb_trans_id_o), 64'd0);
        cycle();
        for (int t = 0; t < 4; t++) begin
            drive(1'b0, 4, 0, 1'b0, 0, 64'h0, 1'b1, 1'b0);
            #1;
            chk("bp_retire_tid", 64'(bus.wb_trans_id_o), 64'(t));
            cycle();
        end
        idle(1'b1);
        #1;
        chk("bp_ready_back", 64'(bus.issue_ready_o), 64'd1);
        cycle();

        // Out of order completion.
        drive(1'b1, 1, 5, 1'b0, 0, 64'h0, 1'b1, 1'b0);  cycle();
        drive(1'b1, 0, 6, 1'b0, 0, 64'h0, 1'b1, 1'b0);  cycle();
        drive(1'b0, 0, 0, 1'b1, 0, 64'hAA, 1'b1, 1'b0); cycle();
        drive(1'b0, 0, 0, 1'b1, 1, 64'hBB, 1'b1, 1'b0);
        #1;
        chk("ooo_first_addr", 64'(bus.waddr_o), 64'd6);
        chk("ooo_first_data", bus.wdata_o,      64'hAA);
        cycle();
        idle(1'b1);
        #1;
        chk("ooo_second_addr", 64'(bus.waddr_o), 64'd5);
        chk("ooo_second_data", bus.wdata_o,      64'hBB);
        cycle();

        // Write to x0 retires without a write; result on an unissued tag is an error.
        drive(1'b1, 3, 0, 1'b0, 0, 64'h0, 1'b0, 1'b0);    cycle();
        drive(1'b0, 0, 0, 1'b1, 3, 64'h1234, 1'b0, 1'b0); cycle();
        idle(1'b0);
        #1;
        chk("x0_valid", 64'(bus.wb_valid_o), 64'd1);
        chk("x0_we",    64'(bus.we_o),       64'd0);
        cycle();
        idle(1'b1); cycle();
        drive(1'b0, 0, 0, 1'b1, 7, 64'h55, 1'b1, 1'b0); cycle();
        idle(1'b1);
        #1;
        chk("err_set", 64'(bus.err_o), 64'd1);
        chk("err_dropped", 64'(bus.wb_valid_o), 64'd0);
        cycle();
        idle(1'b1); cycle();

        // Flush with two queued results and one pending tag.
        drive(1'b1, 0, 1, 1'b0, 0, 64'h0, 1'b0, 1'b0);   cycle();
        drive(1'b0, 0, 0, 1'b1, 0, 64'h11, 1'b0, 1'b0);  cycle();
        drive(1'b1, 1, 2, 1'b0, 0, 64'h0, 1'b0, 1'b0);   cycle();
        drive(1'b0, 0, 0, 1'b1, 1, 64'h22, 1'b0, 1'b0);  cycle();
        drive(1'b1, 2, 3, 1'b0, 0, 64'h0, 1'b0, 1'b0);   cycle();
        drive(1'b1, 4, 9, 1'b0, 0, 64'h0, 1'b1, 1'b1);
        #1;
        chk("flush_valid", 64'(bus.wb_valid_o), 64'd0);
        chk("flush_we",    64'(bus.we_o),       64'd0);
        cycle();
        drive(1'b0, 2, 0, 1'b0, 0, 64'h0, 1'b1, 1'b0);
        #1;
        chk("post_flush_valid", 64'(bus.wb_valid_o),    64'd0);
        chk("post_flush_tag2",  64'(bus.issue_ready_o), 64'd1);
        chk("post_flush_err",   64'(bus.err_o),         64'd1);
        cycle();

        // Asynchronous reset while an entry waits at the head.
        drive(1'b1, 5, 7, 1'b0, 0, 64'h0, 1'b0, 1'b0);      cycle();
        drive(1'b0, 0, 0, 1'b1, 5, 64'hDEAD, 1'b0, 1'b0);   cycle();
        idle(1'b0);
        #1;
        chk("drain_valid", 64'(bus.wb_valid_o), 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_valid", 64'(bus.wb_valid_o),    64'd0);
        chk("arst_we",    64'(bus.we_o),          64'd0);
        chk("arst_waddr", 64'(bus.waddr_o),       64'd0);
        chk("arst_wdata", bus.wdata_o,            64'd0);
        chk("arst_tid",   64'(bus.wb_trans_id_o), 64'd0);
        chk("arst_err",   64'(bus.err_o),         64'd0);
        chk("arst_ready", 64'(bus.issue_ready_o), 64'd1);
        model_reset();
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Randomized traffic, results mostly for pending tags.
        for (int n = 0; n < 400; n++) begin
            int mt;
            pend.delete();
            for (int i = 0; i < 8; i++) if (m_tv[i]) pend.push_back(i);
            if (pend.size() > 0 && ($urandom % 8) != 0)
                mt = pend[$urandom % pend.size()];
            else
                mt = int'($urandom % 8);
            drive(($urandom % 2) == 0, int'($urandom % 8), int'($urandom % 32),
                  ($urandom % 3) != 0, mt, {$urandom, $urandom},
                  ($urandom % 4) != 0, ($urandom % 40) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
